// File: rtl/instr_decode_pkg.sv
// Shared widths, field-offset helpers and constants for the instruction decode buffer.
// Default widths describe a 16-bit word: [15:12] op, [11:8] A, [7:4] ext op, [3:0] B.
// The immediate is the low EXT_OP_CODE_BITS + REG_BITS bits of the word.
package instr_decode_pkg;

    localparam int unsigned DefWidth          = 16;
    localparam int unsigned DefRegBits        = 4;
    localparam int unsigned DefOpCodeBits     = 4;
    localparam int unsigned DefExtOpCodeBits  = 4;
    localparam int unsigned DefCntBits        = 8;
    localparam int unsigned DefRtypeOpcode    = 0;

    // Field offsets for the default widths.
    localparam int unsigned DefOpLsb  = DefWidth - DefOpCodeBits;
    localparam int unsigned DefALsb   = DefOpLsb - DefRegBits;
    localparam int unsigned DefExtLsb = DefRegBits;
    localparam int unsigned DefBLsb   = 0;

    // Immediate occupies the ext op code and B index fields.
    function automatic int unsigned imm_bits(input int unsigned ext_bits,
                                             input int unsigned reg_bits);
        return ext_bits + reg_bits;
    endfunction

    // LSB of the A index field for arbitrary widths.
    function automatic int unsigned a_lsb(input int unsigned width,
                                          input int unsigned op_bits,
                                          input int unsigned reg_bits);
        return width - op_bits - reg_bits;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field splitter for one instruction word.
// Ports:
//   instr_i        raw instruction word
//   op_code_o      major op code (top bits)
//   a_index_o      A register index (below op code)
//   ext_op_code_o  extended op code (below A index)
//   b_index_o      B register index (low bits)
//   immediate_o    low IMM_BITS, sign- or zero-extended per SIGN_EXT_MASK[op_code]
//   is_rtype_o     op code equals RTYPE_OPCODE
module instr_field_decode
    import instr_decode_pkg::*;
#(
    parameter int unsigned WIDTH            = DefWidth,
    parameter int unsigned REG_BITS         = DefRegBits,
    parameter int unsigned OP_CODE_BITS     = DefOpCodeBits,
    parameter int unsigned EXT_OP_CODE_BITS = DefExtOpCodeBits,
    parameter logic [2**OP_CODE_BITS-1:0] SIGN_EXT_MASK = '0,
    parameter int unsigned RTYPE_OPCODE     = DefRtypeOpcode
) (
    input  logic [WIDTH-1:0]            instr_i,
    output logic [OP_CODE_BITS-1:0]     op_code_o,
    output logic [REG_BITS-1:0]         a_index_o,
    output logic [EXT_OP_CODE_BITS-1:0] ext_op_code_o,
    output logic [REG_BITS-1:0]         b_index_o,
    output logic [WIDTH-1:0]            immediate_o,
    output logic                        is_rtype_o
);

    localparam int unsigned ImmBits = imm_bits(EXT_OP_CODE_BITS, REG_BITS);
    localparam int unsigned ALsb    = a_lsb(WIDTH, OP_CODE_BITS, REG_BITS);
    localparam int unsigned ExtLsb  = REG_BITS;

    logic [ImmBits-1:0] imm_raw;
    logic               sign_fill;

    assign op_code_o     = instr_i[WIDTH-1 -: OP_CODE_BITS];
    assign a_index_o     = instr_i[ALsb +: REG_BITS];
    assign ext_op_code_o = instr_i[ExtLsb +: EXT_OP_CODE_BITS];
    assign b_index_o     = instr_i[REG_BITS-1:0];
    assign imm_raw       = instr_i[ImmBits-1:0];

    // Extension policy follows this word's own op code.
    assign sign_fill   = SIGN_EXT_MASK[op_code_o] & imm_raw[ImmBits-1];
    assign immediate_o = {{(WIDTH-ImmBits){sign_fill}}, imm_raw};
    assign is_rtype_o  = (op_code_o == OP_CODE_BITS'(RTYPE_OPCODE));

endmodule

// File: rtl/instr_decode_buffer.sv
// Registered, valid/ready decode buffer: output register plus one skid entry.
// Words are decoded on entry so both entries hold pre-decoded fields and all field
// outputs come straight from registers.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   flush                      drop both entries (counter kept)
//   in_valid/in_ready          fetch handshake, in_instruction is the offered word
//   out_valid/out_ready        consumer handshake for the decoded fields
//   op_code .. is_rtype        decoded fields of the head entry
//   accepted_count             wrapping count of accepted words
module instr_decode_buffer
    import instr_decode_pkg::*;
#(
    parameter int unsigned WIDTH            = DefWidth,
    parameter int unsigned REG_BITS         = DefRegBits,
    parameter int unsigned OP_CODE_BITS     = DefOpCodeBits,
    parameter int unsigned EXT_OP_CODE_BITS = DefExtOpCodeBits,
    parameter logic [2**OP_CODE_BITS-1:0] SIGN_EXT_MASK = '0,
    parameter int unsigned RTYPE_OPCODE     = DefRtypeOpcode,
    parameter int unsigned CNT_BITS         = DefCntBits
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_instruction,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_CODE_BITS-1:0]     op_code,
    output logic [REG_BITS-1:0]         A_index_out,
    output logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
    output logic [REG_BITS-1:0]         B_index_out,
    output logic [WIDTH-1:0]            immediate_value,
    output logic                        is_rtype,
    output logic [CNT_BITS-1:0]         accepted_count
);

    if (OP_CODE_BITS + 2 * REG_BITS + EXT_OP_CODE_BITS != WIDTH) begin : g_width_check
        $fatal(1, "instr_decode_buffer: field widths do not sum to WIDTH");
    end

    localparam int unsigned FieldBits = OP_CODE_BITS + 2 * REG_BITS + EXT_OP_CODE_BITS + WIDTH + 1;

    logic [OP_CODE_BITS-1:0]     dec_op;
    logic [REG_BITS-1:0]         dec_a;
    logic [EXT_OP_CODE_BITS-1:0] dec_ext;
    logic [REG_BITS-1:0]         dec_b;
    logic [WIDTH-1:0]            dec_imm;
    logic                        dec_rtype;
    logic [FieldBits-1:0]        dec_fields;

    logic                 out_valid_q, out_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [FieldBits-1:0] out_fields_q, out_fields_d;
    logic [FieldBits-1:0] skid_fields_q, skid_fields_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 accept;

    instr_field_decode #(
        .WIDTH            (WIDTH),
        .REG_BITS         (REG_BITS),
        .OP_CODE_BITS     (OP_CODE_BITS),
        .EXT_OP_CODE_BITS (EXT_OP_CODE_BITS),
        .SIGN_EXT_MASK    (SIGN_EXT_MASK),
        .RTYPE_OPCODE     (RTYPE_OPCODE)
    ) u_decode (
        .instr_i       (in_instruction),
        .op_code_o     (dec_op),
        .a_index_o     (dec_a),
        .ext_op_code_o (dec_ext),
        .b_index_o     (dec_b),
        .immediate_o   (dec_imm),
        .is_rtype_o    (dec_rtype)
    );

    assign dec_fields = {dec_op, dec_a, dec_ext, dec_b, dec_imm, dec_rtype};

    assign in_ready = !skid_valid_q && !flush && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        out_fields_d  = out_fields_q;
        skid_fields_d = skid_fields_q;
        count_d       = count_q;
        if (flush) begin
            // Fields are left as they were; only the valid bits are cleared.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (!out_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_fields_d = skid_fields_q;
                    skid_valid_d = accept;
                    if (accept) begin
                        skid_fields_d = dec_fields;
                    end
                end else begin
                    out_valid_d = accept;
                    if (accept) begin
                        out_fields_d = dec_fields;
                    end
                end
            end else if (accept) begin
                skid_valid_d  = 1'b1;
                skid_fields_d = dec_fields;
            end
            count_d = count_q + CNT_BITS'(accept);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            out_fields_q  <= '0;
            skid_fields_q <= '0;
            count_q       <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            out_fields_q  <= out_fields_d;
            skid_fields_q <= skid_fields_d;
            count_q       <= count_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign accepted_count = count_q;
    assign {op_code, A_index_out, ext_op_code, B_index_out, immediate_value, is_rtype} =
        out_fields_q;

endmodule

// File: tb/tb_instr_decode_buffer.sv
module tb_instr_decode_buffer;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_instruction, immediate_value;
    logic [3:0]  op_code, A_index_out, ext_op_code, B_index_out;
    logic        is_rtype;
    logic [1:0]  accepted_count;

    int checks = 0;
    int failures = 0;

    // Reference model: FIFO of raw words (at most two) and an accept counter.
    logic [15:0] mq[$];
    int          mcnt = 0;

    always #5 clk = ~clk;

    instr_decode_buffer #(
        .WIDTH            (16),
        .REG_BITS         (4),
        .OP_CODE_BITS     (4),
        .EXT_OP_CODE_BITS (4),
        .SIGN_EXT_MASK    (16'h0020),
        .RTYPE_OPCODE     (0),
        .CNT_BITS         (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .op_code         (op_code),
        .A_index_out     (A_index_out),
        .ext_op_code     (ext_op_code),
        .B_index_out     (B_index_out),
        .immediate_value (immediate_value),
        .is_rtype        (is_rtype),
        .accepted_count  (accepted_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_imm(input int w);
        int op  = w / 4096;
        int imm = w % 256;
        if (((16'h0020 >> op) & 1) == 1 && imm >= 128) imm = imm + 16'hFF00;
        return imm;
    endfunction

    // One clock: drive, check in_ready mid-cycle, clock, update model, check outputs.
    task automatic cycle(input logic v, input logic [15:0] w, input logic rdy,
                         input logic fl, input logic rst);
        logic exp_ready, acc;
        int   h;
        in_valid = v; in_instruction = w; out_ready = rdy; flush = fl; reset = rst;
        #4;
        exp_ready = (mq.size() < 2) && !fl && !rst;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(w);
                mcnt = (mcnt + 1) % 4;
            end
        end
        #1;
        check("out_valid", {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        check("accepted_count", {30'd0, accepted_count}, mcnt);
        if (mq.size() > 0) begin
            h = int'(mq[0]);
            check("op_code", {28'd0, op_code}, h / 4096);
            check("A_index", {28'd0, A_index_out}, (h / 256) % 16);
            check("ext_op_code", {28'd0, ext_op_code}, (h / 16) % 16);
            check("B_index", {28'd0, B_index_out}, h % 16);
            check("immediate", {16'd0, immediate_value}, ref_imm(h));
            check("is_rtype", {31'd0, is_rtype}, (h / 4096 == 0) ? 32'd1 : 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op, a, ext, b;
        logic [15:0] imm;
        logic        rt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{16'h5A3F, 4'h5, 4'hA, 4'h3, 4'hF, 16'h003F, 1'b0};
        tbl[1] = '{16'h5A8F, 4'h5, 4'hA, 4'h8, 4'hF, 16'hFF8F, 1'b0};
        tbl[2] = '{16'h6A8F, 4'h6, 4'hA, 4'h8, 4'hF, 16'h008F, 1'b0};
        tbl[3] = '{16'h0123, 4'h0, 4'h1, 4'h2, 4'h3, 16'h0023, 1'b1};
        tbl[4] = '{16'h5A7F, 4'h5, 4'hA, 4'h7, 4'hF, 16'h007F, 1'b0};

        in_valid = 0; in_instruction = 0; out_ready = 0; flush = 0; reset = 1;
        @(posedge clk);
        #1;

        // Reset state.
        cycle(0, 16'h0, 0, 0, 1);
        cycle(0, 16'h0, 0, 0, 1);
        check("rst_imm", {16'd0, immediate_value}, 0);
        check("rst_op", {28'd0, op_code}, 0);
        check("rst_B", {28'd0, B_index_out}, 0);

        // Table vectors, one per cycle, consumer always ready.
        for (int i = 0; i < 5; i++) begin
            cycle(1, tbl[i].instr, 1, 0, 0);
            check("tbl_op", {28'd0, op_code}, {28'd0, tbl[i].op});
            check("tbl_A", {28'd0, A_index_out}, {28'd0, tbl[i].a});
            check("tbl_ext", {28'd0, ext_op_code}, {28'd0, tbl[i].ext});
            check("tbl_B", {28'd0, B_index_out}, {28'd0, tbl[i].b});
            check("tbl_imm", {16'd0, immediate_value}, {16'd0, tbl[i].imm});
            check("tbl_rtype", {31'd0, is_rtype}, {31'd0, tbl[i].rt});
            if (i == 0) check("tbl_count0", {30'd0, accepted_count}, 1);
        end

        // Back-pressure: third word must wait, order preserved on drain.
        cycle(0, 16'h0, 0, 0, 1);
        cycle(1, 16'h1111, 0, 0, 0);
        cycle(1, 16'h2222, 0, 0, 0);
        cycle(1, 16'h3333, 0, 0, 0);
        check("full_in_ready", {31'd0, in_ready}, 0);
        check("held_op", {28'd0, op_code}, 1);
        cycle(1, 16'h3333, 1, 0, 0);
        check("drain_op2", {28'd0, op_code}, 2);
        cycle(1, 16'h3333, 1, 0, 0);
        check("drain_op3", {28'd0, op_code}, 3);
        cycle(0, 16'h0, 1, 0, 0);
        check("drain_empty", {31'd0, out_valid}, 0);
        check("drain_count", {30'd0, accepted_count}, 3);

        // Flush while full with a word offered.
        cycle(1, 16'h4444, 0, 0, 0);
        cycle(1, 16'h5555, 0, 0, 0);
        cycle(1, 16'h6666, 0, 1, 0);
        check("flush_valid", {31'd0, out_valid}, 0);
        check("flush_count", {30'd0, accepted_count}, 1);
        in_valid = 0; flush = 0;
        #4;
        check("flush_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Counter wrap with CNT_BITS=2, then reset mid-stream.
        cycle(0, 16'h0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'h7000 + 16'(i), 1, 0, 0);
            check("wrap_count", {30'd0, accepted_count}, (i + 1) % 4);
        end
        cycle(1, 16'h7777, 1, 0, 1);
        check("midrst_valid", {31'd0, out_valid}, 0);
        check("midrst_count", {30'd0, accepted_count}, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
